// File: rtl/conv_job_scheduler.sv
// Binary-convolution job scheduler: queues host descriptors in a small FIFO and
// dispatches them one at a time to the conv engine through a run/busy handshake.
module conv_job_scheduler #(
  parameter int unsigned Depth   = 4,
  parameter int unsigned Aw      = 12,
  parameter int unsigned Timeout = 15
) (
  input  logic                     clk_i,
  input  logic                     reset_b_i,
  input  logic                     desc_valid_i,
  output logic                     desc_ready_o,
  input  logic [Aw-1:0]            desc_in_base_i,
  input  logic [Aw-1:0]            desc_out_base_i,
  input  logic [Aw-1:0]            desc_w_addr_i,
  input  logic                     enable_i,
  input  logic                     abort_i,
  output logic                     eng_run_o,
  output logic [Aw-1:0]            eng_in_base_o,
  output logic [Aw-1:0]            eng_out_base_o,
  output logic [Aw-1:0]            eng_w_addr_o,
  input  logic                     eng_busy_i,
  output logic                     job_done_o,
  output logic                     job_err_o,
  output logic [7:0]               done_cnt_o,
  output logic [$clog2(Depth):0]   fifo_level_o,
  output logic                     sched_busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned TmoW = $clog2(Timeout + 1);

  typedef enum logic [2:0] {
    StIdle, StLaunch, StWaitBusy, StRun, StDone, StErr, StDrain
  } state_e;

  state_e            state_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic [3*Aw-1:0]   mem_q [Depth];
  logic [3*Aw-1:0]   head;
  logic [TmoW-1:0]   tmo_q;
  logic [Aw-1:0]     eng_in_base_q, eng_out_base_q, eng_w_addr_q;
  logic              eng_run_q, job_done_q, job_err_q;
  logic [7:0]        done_cnt_q;
  logic              push, pop;

  // Full FIFO refuses pushes even if a pop lands in the same cycle; abort discards pushes.
  assign desc_ready_o = (level_q != LvlW'(Depth));
  assign push         = desc_valid_i & desc_ready_o & ~abort_i;
  assign pop          = (state_q == StLaunch) & ~abort_i;
  assign head         = mem_q[rd_ptr_q];

  // Next FIFO occupancy from this cycle's push/pop.
  always_comb begin
    level_d = level_q + LvlW'(push) - LvlW'(pop);
  end

  // FIFO pointers and level; abort flushes everything.
  always_ff @(posedge clk_i) begin
    if (reset_b_i || abort_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      level_q <= level_d;
    end
  end

  // Descriptor storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {desc_in_base_i, desc_out_base_i, desc_w_addr_i};
  end

  // Dispatch FSM with registered pulse outputs and held engine addresses.
  always_ff @(posedge clk_i) begin
    if (reset_b_i) begin
      state_q        <= StIdle;
      tmo_q          <= '0;
      eng_in_base_q  <= '0;
      eng_out_base_q <= '0;
      eng_w_addr_q   <= '0;
      eng_run_q      <= 1'b0;
      job_done_q     <= 1'b0;
      job_err_q      <= 1'b0;
      done_cnt_q     <= '0;
    end else begin
      eng_run_q  <= 1'b0;
      job_done_q <= 1'b0;
      job_err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (enable_i && (level_q != '0) && !abort_i) state_q <= StLaunch;
        end
        StLaunch: begin
          if (abort_i) begin
            state_q <= StIdle;
          end else begin
            {eng_in_base_q, eng_out_base_q, eng_w_addr_q} <= head;
            eng_run_q <= 1'b1;
            tmo_q     <= '0;
            state_q   <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (abort_i) begin
            state_q <= eng_busy_i ? StDrain : StIdle;
          end else if (eng_busy_i) begin
            state_q <= StRun;
          end else if (tmo_q == TmoW'(Timeout)) begin
            job_err_q <= 1'b1;
            state_q   <= StErr;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StRun: begin
          if (abort_i) begin
            state_q <= eng_busy_i ? StDrain : StIdle;
          end else if (!eng_busy_i) begin
            job_done_q <= 1'b1;
            if (done_cnt_q != 8'hff) done_cnt_q <= done_cnt_q + 8'd1;
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        StDrain: begin
          if (!eng_busy_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign eng_run_o      = eng_run_q;
  assign eng_in_base_o  = eng_in_base_q;
  assign eng_out_base_o = eng_out_base_q;
  assign eng_w_addr_o   = eng_w_addr_q;
  assign job_done_o     = job_done_q;
  assign job_err_o      = job_err_q;
  assign done_cnt_o     = done_cnt_q;
  assign fifo_level_o   = level_q;
  assign sched_busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Bench for conv_job_scheduler: behavioural engine, descriptor queue model and
// event monitor, driven by a linear sequence of directed and randomized steps.
module tb_conv_job_scheduler;

  localparam int Timeout = 15;

  logic        clk = 1'b0;
  logic        reset_b, desc_valid, desc_ready, enable, abort;
  logic [11:0] desc_in_base, desc_out_base, desc_w_addr;
  logic        eng_run, eng_busy, job_done, job_err, sched_busy;
  logic [11:0] eng_in_base, eng_out_base, eng_w_addr;
  logic [7:0]  done_cnt;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  conv_job_scheduler dut (
    .clk_i           (clk),
    .reset_b_i       (reset_b),
    .desc_valid_i    (desc_valid),
    .desc_ready_o    (desc_ready),
    .desc_in_base_i  (desc_in_base),
    .desc_out_base_i (desc_out_base),
    .desc_w_addr_i   (desc_w_addr),
    .enable_i        (enable),
    .abort_i         (abort),
    .eng_run_o       (eng_run),
    .eng_in_base_o   (eng_in_base),
    .eng_out_base_o  (eng_out_base),
    .eng_w_addr_o    (eng_w_addr),
    .eng_busy_i      (eng_busy),
    .job_done_o      (job_done),
    .job_err_o       (job_err),
    .done_cnt_o      (done_cnt),
    .fifo_level_o    (fifo_level),
    .sched_busy_o    (sched_busy)
  );

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: accepted descriptors in order, and completed-job count.
  logic [35:0] model_q[$];
  int          model_done = 0;

  // Behavioural engine: after each run pulse, idle for a delay, then busy for a length.
  bit eng_dead  = 1'b0;
  bit eng_fixed = 1'b0;
  int fix_delay = 0, fix_len = 1;
  int wait_cnt  = 0, busy_cnt = 0;
  initial begin
    eng_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (eng_run && !eng_dead) begin
        if (eng_fixed) begin
          wait_cnt = fix_delay;
          busy_cnt = fix_len;
        end else begin
          wait_cnt = int'($urandom_range(0, 3));
          busy_cnt = int'($urandom_range(1, 6));
        end
      end
      if (wait_cnt > 0) begin
        wait_cnt--;
        eng_busy = 1'b0;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        eng_busy = 1'b1;
      end else begin
        eng_busy = 1'b0;
      end
    end
  end

  // Monitor: pulse counts, launch order, pulse timing and address stability.
  int          n_run = 0, n_done = 0, n_err = 0;
  int unsigned last_run_cyc = 0, last_fall_cyc = 0;
  logic        prev_busy = 1'b0, prev_run = 1'b0, prev_done = 1'b0;
  logic [35:0] last_launch = '0;
  always @(negedge clk) begin
    if (!reset_b) begin
      if (eng_run) begin
        check("run_single_cycle", {63'd0, prev_run}, 64'd0);
        check("launch_nonempty", {63'd0, model_q.size() > 0}, 64'd1);
        if (model_q.size() > 0)
          check("launch_order", {28'd0, eng_in_base, eng_out_base, eng_w_addr},
                {28'd0, model_q.pop_front()});
        last_launch  = {eng_in_base, eng_out_base, eng_w_addr};
        last_run_cyc = cyc;
        n_run++;
      end
      check("eng_addr_stable", {28'd0, eng_in_base, eng_out_base, eng_w_addr},
            {28'd0, last_launch});
      if (prev_busy && !eng_busy) last_fall_cyc = cyc;
      if (job_done) begin
        check("done_single_cycle", {63'd0, prev_done}, 64'd0);
        check("done_after_fall", 64'(cyc - last_fall_cyc), 64'd1);
        n_done++;
      end
      if (job_err) begin
        check("err_after_run", 64'(cyc - last_run_cyc), 64'(1 + Timeout));
        n_err++;
      end
      prev_busy = eng_busy;
      prev_run  = eng_run;
      prev_done = job_done;
    end
  end

  task automatic push_desc(input logic [35:0] d, input logic exp_ready);
    desc_valid = 1'b1;
    {desc_in_base, desc_out_base, desc_w_addr} = d;
    check("desc_ready", {63'd0, desc_ready}, {63'd0, exp_ready});
    if (exp_ready && !abort) model_q.push_back(d);
    step();
    desc_valid = 1'b0;
  endtask

  task automatic wait_for(input string tag, input int tgt_done, input int tgt_err,
                          input int budget);
    int n = 0;
    while ((n_done < tgt_done || n_err < tgt_err) && n < budget) begin
      step();
      n++;
    end
    check(tag, {63'd0, n < budget}, 64'd1);
  endtask

  function automatic logic [35:0] rand_desc();
    return 36'({$urandom(), $urandom()});
  endfunction

  initial begin
    logic [35:0] d;
    int          runs0, done0;
    reset_b = 1'b1; desc_valid = 1'b0; enable = 1'b0; abort = 1'b0;
    desc_in_base = '0; desc_out_base = '0; desc_w_addr = '0;

    // Reset state.
    step(); step();
    check("rst_desc_ready", {63'd0, desc_ready}, 64'd1);
    check("rst_eng_run", {63'd0, eng_run}, 64'd0);
    check("rst_eng_addrs", {28'd0, eng_in_base, eng_out_base, eng_w_addr}, 64'd0);
    check("rst_pulses", {62'd0, job_done, job_err}, 64'd0);
    check("rst_done_cnt", {56'd0, done_cnt}, 64'd0);
    check("rst_fifo_level", {61'd0, fifo_level}, 64'd0);
    check("rst_sched_busy", {63'd0, sched_busy}, 64'd0);
    reset_b = 1'b0;
    step();

    // Single job, engine busy for 20 cycles after a 2-cycle delay.
    eng_fixed = 1'b1; fix_delay = 2; fix_len = 20;
    enable = 1'b1;
    push_desc({12'h000, 12'h100, 12'h001}, 1'b1);
    wait_for("t2_done_wait", 1, 0, 100);
    model_done++;
    check("t2_runs", 64'(n_run), 64'd1);
    check("t2_in_base", {52'd0, eng_in_base}, 64'h000);
    check("t2_done_cnt", {56'd0, done_cnt}, 64'(model_done));
    step();
    check("t2_idle", {63'd0, sched_busy}, 64'd0);

    // Fill with dispatch disabled: 5th push stalls, then drain in order.
    eng_fixed = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) push_desc(rand_desc(), model_q.size() < 4);
    check("t3_level_full", {61'd0, fifo_level}, 64'(model_q.size()));
    check("t3_ready_low", {63'd0, desc_ready}, 64'd0);
    enable = 1'b1;
    wait_for("t3_done_wait", n_done + 4, 0, 300);
    model_done += 4;
    check("t3_done_cnt", {56'd0, done_cnt}, 64'(model_done));
    check("t3_level_empty", {61'd0, fifo_level}, 64'd0);

    // Dead engine: each job times out, next queued job still launches.
    eng_dead = 1'b1;
    runs0 = n_run; done0 = n_done;
    push_desc(rand_desc(), 1'b1);
    push_desc(rand_desc(), 1'b1);
    wait_for("t4_err_wait", 0, 2, 150);
    check("t4_runs", 64'(n_run - runs0), 64'd2);
    check("t4_no_done", 64'(n_done - done0), 64'd0);
    check("t4_done_cnt", {56'd0, done_cnt}, 64'(model_done));
    eng_dead = 1'b0;
    step(); step();

    // Abort during RUN with three queued jobs.
    eng_fixed = 1'b1; fix_delay = 0; fix_len = 30;
    runs0 = n_run; done0 = n_done;
    for (int i = 0; i < 4; i++) push_desc(rand_desc(), 1'b1);
    for (int i = 0; i < 6; i++) step();
    check("t5_running", {63'd0, eng_busy}, 64'd1);
    check("t5_level", {61'd0, fifo_level}, 64'(model_q.size()));
    abort = 1'b1;
    model_q.delete();
    push_desc(rand_desc(), 1'b1);
    abort = 1'b0;
    check("t5_flushed", {61'd0, fifo_level}, 64'd0);
    check("t5_draining", {63'd0, sched_busy}, 64'd1);
    for (int i = 0; i < 40 && eng_busy; i++) step();
    step(); step();
    check("t5_idle", {63'd0, sched_busy}, 64'd0);
    for (int i = 0; i < 20; i++) step();
    check("t5_no_more_runs", 64'(n_run - runs0), 64'd1);
    check("t5_no_done", 64'(n_done - done0), 64'd0);

    // Held abort: ready stays high but pushes are dropped.
    abort = 1'b1;
    push_desc(rand_desc(), 1'b1);
    check("abort_hold_level", {61'd0, fifo_level}, 64'd0);
    check("abort_hold_idle", {63'd0, sched_busy}, 64'd0);
    abort = 1'b0;
    step();

    // Saturate the completion counter, then one more job.
    eng_fixed = 1'b0;
    while (model_done < 256) begin
      d = rand_desc();
      push_desc(d, 1'b1);
      wait_for("t6_done_wait", n_done + 1, 0, 60);
      if (model_done < 255) model_done++;
      else model_done = 256;
      if (model_done == 255) check("t6_sat_cnt", {56'd0, done_cnt}, 64'd255);
    end
    check("t6_hold_cnt", {56'd0, done_cnt}, 64'd255);
    check("t6_model_empty", 64'(model_q.size()), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
